// File: rtl/darkboot_pkg.sv
// rtl/darkboot_pkg.sv - shared state encoding and constants for the darkboot serial loader
package darkboot_pkg;

    typedef enum logic [3:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_VERIFY,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_OVR  = 2'd3;

endpackage

// File: rtl/darkboot_asm.sv
// rtl/darkboot_asm.sv - little-endian byte-to-word assembler with running 8-bit data sum
module darkboot_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        stb,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_rdy,
    output logic [7:0]  sum
);

    logic [1:0]  lane;
    logic [23:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            sh   <= 24'd0;
            sum  <= 8'd0;
        end else if (clr) begin
            lane <= 2'd0;
            sh   <= 24'd0;
            sum  <= 8'd0;
        end else if (stb) begin
            lane <= lane + 2'd1;
            sh   <= {data, sh[23:8]};
            sum  <= sum + data;
        end
    end

    // The fourth byte is not stored; it goes straight into the top lane of the word.
    assign word     = {data, sh};
    assign word_rdy = stb && (lane == 2'd3);

endmodule

// File: rtl/darkboot.sv
// rtl/darkboot.sv - serial boot loader FSM and RAM write handshake (optional DARKBOOT_READBACK_EN)
module darkboot
    import darkboot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic [7:0]  RXD,
    input  logic        RXSTB,
    output logic        XDREQ,
    output logic        XWR,
    output logic        XRD,
    output logic [3:0]  XBE,
    output logic [31:0] XADDR,
    output logic [31:0] XATAI,
    input  logic [31:0] XATAO,
    input  logic        XDACK,
    output logic        CORE_RES,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERRCODE
);

    state_t      state, state_d;
    logic [7:0]  len_lo, len_lo_d;
    logic [15:0] len, len_d;
    logic [15:0] idx, idx_d, idx_inc;
    logic        xdreq, xdreq_d, xwr, xwr_d;
    logic [31:0] xaddr, xaddr_d, xatai, xatai_d;
    logic        core_res, core_res_d, done, done_d, err, err_d;
    logic [1:0]  errcode, errcode_d;
    logic [15:0] len_rx;

    logic        asm_clr, asm_stb, word_rdy;
    logic [31:0] word;
    logic [7:0]  sum;

`ifdef DARKBOOT_READBACK_EN
    logic        xrd, xrd_d;
`else
    logic [31:0] unused_atao;
    assign unused_atao = XATAO;
`endif

    assign asm_stb = RXSTB && (state == S_DATA);
    assign asm_clr = RXSTB && (RXD == SYNC_BYTE) && ((state == S_SYNC) || (state == S_ERROR));
    assign idx_inc = idx + 16'd1;
    assign len_rx  = {RXD, len_lo};

    darkboot_asm u_asm (
        .clk      (CLK),
        .rst_n    (RESN),
        .clr      (asm_clr),
        .stb      (asm_stb),
        .data     (RXD),
        .word     (word),
        .word_rdy (word_rdy),
        .sum      (sum)
    );

    always_comb begin
        state_d    = state;
        len_lo_d   = len_lo;
        len_d      = len;
        idx_d      = idx;
        xdreq_d    = xdreq;
        xwr_d      = xwr;
        xaddr_d    = xaddr;
        xatai_d    = xatai;
        core_res_d = core_res;
        done_d     = done;
        err_d      = err;
        errcode_d  = errcode;
`ifdef DARKBOOT_READBACK_EN
        xrd_d      = xrd;
`endif
        case (state)
            S_SYNC: begin
                if (asm_clr) begin
                    state_d = S_LEN0;
                    idx_d   = 16'd0;
                end
            end
            S_LEN0: begin
                if (RXSTB) begin
                    len_lo_d = RXD;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (RXSTB) begin
                    len_d = len_rx;
                    if ({16'd0, len_rx} > MAX_WORDS) begin
                        state_d   = S_ERROR;
                        err_d     = 1'b1;
                        errcode_d = ERR_LEN;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_rdy) begin
                    state_d = S_WRITE;
                    xdreq_d = 1'b1;
                    xwr_d   = 1'b1;
                    xaddr_d = BASE_ADDR + {14'd0, idx, 2'b00};
                    xatai_d = word;
                end
            end
            S_WRITE: begin
                // A byte arriving while the RAM is still busy would be lost, so abort the load.
                if (RXSTB) begin
                    state_d   = S_ERROR;
                    err_d     = 1'b1;
                    errcode_d = ERR_OVR;
                    xdreq_d   = 1'b0;
                    xwr_d     = 1'b0;
                end else if (XDACK) begin
                    xwr_d = 1'b0;
                    idx_d = idx_inc;
`ifdef DARKBOOT_READBACK_EN
                    xrd_d   = 1'b1;
                    state_d = S_VERIFY;
`else
                    xdreq_d = 1'b0;
                    state_d = (idx_inc == len) ? S_CSUM : S_DATA;
`endif
                end
            end
`ifdef DARKBOOT_READBACK_EN
            S_VERIFY: begin
                if (RXSTB || (XDACK && (XATAO != xatai))) begin
                    state_d   = S_ERROR;
                    err_d     = 1'b1;
                    errcode_d = ERR_OVR;
                    xdreq_d   = 1'b0;
                    xrd_d     = 1'b0;
                end else if (XDACK) begin
                    xdreq_d = 1'b0;
                    xrd_d   = 1'b0;
                    state_d = (idx == len) ? S_CSUM : S_DATA;
                end
            end
`endif
            S_CSUM: begin
                if (RXSTB) begin
                    if (RXD == sum) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        core_res_d = 1'b0;
                    end else begin
                        state_d   = S_ERROR;
                        err_d     = 1'b1;
                        errcode_d = ERR_CSUM;
                    end
                end
            end
            S_DONE: begin
            end
            S_ERROR: begin
                if (asm_clr) begin
                    state_d   = S_LEN0;
                    idx_d     = 16'd0;
                    err_d     = 1'b0;
                    errcode_d = 2'd0;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state    <= S_SYNC;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            idx      <= 16'd0;
            xdreq    <= 1'b0;
            xwr      <= 1'b0;
            xaddr    <= 32'd0;
            xatai    <= 32'd0;
            core_res <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            errcode  <= 2'd0;
        end else begin
            state    <= state_d;
            len_lo   <= len_lo_d;
            len      <= len_d;
            idx      <= idx_d;
            xdreq    <= xdreq_d;
            xwr      <= xwr_d;
            xaddr    <= xaddr_d;
            xatai    <= xatai_d;
            core_res <= core_res_d;
            done     <= done_d;
            err      <= err_d;
            errcode  <= errcode_d;
        end
    end

`ifdef DARKBOOT_READBACK_EN
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            xrd <= 1'b0;
        end else begin
            xrd <= xrd_d;
        end
    end
    assign XRD = xrd;
`else
    assign XRD = 1'b0;
`endif

    assign XDREQ    = xdreq;
    assign XWR      = xwr;
    assign XBE      = xdreq ? 4'hF : 4'h0;
    assign XADDR    = xaddr;
    assign XATAI    = xatai;
    assign CORE_RES = core_res;
    assign DONE     = done;
    assign ERR      = err;
    assign ERRCODE  = errcode;

endmodule
